// File: rtl/conv1_window_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : conv1_window_buf_if
// Description : Pixel-stream / window-stream bundle for conv1_window_buf.
//               master = upstream pixel source (also watches the window side)
//               slave  = the window buffer itself
// Signals     : valid_in, data_in[DATA_BITS], sof_in (CONV1_BUF_SOF_EN only)
//               window[KERNEL*KERNEL*DATA_BITS], valid_out, busy, frame_done
// Config      : CONV1_BUF_SOF_EN adds the sof_in start-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv1_window_buf_if #(
  parameter int DATA_BITS = 8,
  parameter int KERNEL    = 5
);
  logic                               valid_in;
  logic [DATA_BITS-1:0]               data_in;
`ifdef CONV1_BUF_SOF_EN
  logic                               sof_in;
`endif
  logic [KERNEL*KERNEL*DATA_BITS-1:0] window;
  logic                               valid_out;
  logic                               busy;
  logic                               frame_done;

`ifdef CONV1_BUF_SOF_EN
  modport master (output valid_in, data_in, sof_in,
                  input  window, valid_out, busy, frame_done);
  modport slave  (input  valid_in, data_in, sof_in,
                  output window, valid_out, busy, frame_done);
`else
  modport master (output valid_in, data_in,
                  input  window, valid_out, busy, frame_done);
  modport slave  (input  valid_in, data_in,
                  output window, valid_out, busy, frame_done);
`endif
endinterface
`default_nettype wire

// File: rtl/conv1_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : conv1_window_buf
// Description : KERNEL x KERNEL sliding-window generator for a raster-ordered
//               single-channel IMG_WIDTH x IMG_WIDTH frame. One window is
//               emitted (registered, one cycle later) for every pixel beat
//               whose full neighbourhood is present.
// Ports       : gclk       - clock, all state on rising edge
//               rst_n      - asynchronous active-low reset
//               bus.slave  - valid_in/data_in[/sof_in] in,
//                            window/valid_out/busy/frame_done out
// Config      : CONV1_BUF_SOF_EN - sof_in forces the beat to pixel (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module conv1_window_buf #(
  parameter int DATA_BITS = 8,
  parameter int IMG_WIDTH = 28,
  parameter int KERNEL    = 5
) (
  input  logic                gclk,
  input  logic                rst_n,
  conv1_window_buf_if.slave   bus
);

  // Full delay line spans (KERNEL-1) rows plus KERNEL pixels. The newest
  // entry is the incoming pixel itself (data_in), so only TAPS-1 registers
  // are needed to hold the rest.
  localparam int TAPS = (KERNEL - 1) * IMG_WIDTH + KERNEL;
  localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int WB   = KERNEL * KERNEL * DATA_BITS;

  localparam logic [CW-1:0] c_last_pos  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] c_win_start = CW'(KERNEL - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_x;
  logic [CW-1:0]        r_y;
  logic [WB-1:0]        r_window;
  logic                 r_valid_out;
  logic                 r_frame_done;
  logic [DATA_BITS-1:0] r_chain [TAPS-1];

  logic [CW-1:0]        w_x;
  logic [CW-1:0]        w_y;
  logic                 w_row_end;
  logic                 w_last;
  logic                 w_win_ok;
  logic [WB-1:0]        w_window;

  // Position of the pixel on the current beat.
`ifdef CONV1_BUF_SOF_EN
  assign w_x = bus.sof_in ? '0 : r_x;
  assign w_y = bus.sof_in ? '0 : r_y;
`else
  assign w_x = r_x;
  assign w_y = r_y;
`endif

  assign w_row_end = (w_x == c_last_pos);
  assign w_last    = w_row_end && (w_y == c_last_pos);
  // Requiring y >= KERNEL-1 also guarantees every tap has been refilled by
  // the current frame, so stale buffer contents never leak into a window.
  assign w_win_ok  = (w_x >= c_win_start) && (w_y >= c_win_start);

  // Delay line: advances only on accepted beats, never reset.
  always_ff @(posedge gclk) begin
    if (bus.valid_in) begin
      r_chain[0] <= bus.data_in;
      for (int i = 1; i < TAPS - 1; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  // Element (r,c) is the pixel (KERNEL-1-r) rows and (KERNEL-1-c) columns
  // behind the current one, i.e. at age (KERNEL-1-r)*IMG_WIDTH+(KERNEL-1-c).
  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_col
      localparam int AGE = (KERNEL - 1 - r) * IMG_WIDTH + (KERNEL - 1 - c);
      if (AGE == 0) begin : g_cur
        assign w_window[(r*KERNEL+c)*DATA_BITS +: DATA_BITS] = bus.data_in;
      end else begin : g_buf
        assign w_window[(r*KERNEL+c)*DATA_BITS +: DATA_BITS] = r_chain[AGE-1];
      end
    end
  end

  // Frame FSM, position counters and registered outputs.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_window     <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.valid_in) begin
        if (w_row_end) begin
          r_x <= '0;
          r_y <= w_last ? '0 : w_y + 1'b1;
        end else begin
          r_x <= w_x + 1'b1;
          r_y <= w_y;
        end

        if (w_win_ok) begin
          r_window    <= w_window;
          r_valid_out <= 1'b1;
        end

        unique case (r_state)
          ST_IDLE: begin
            r_state <= w_last ? ST_IDLE : ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        r_frame_done <= w_last;
      end
    end
  end

  assign bus.window     = r_window;
  assign bus.valid_out  = r_valid_out;
  assign bus.frame_done = r_frame_done;
  // Includes the current beat so busy rises with the first pixel and does
  // not dip when the next frame starts right after the last pixel.
  assign bus.busy       = (r_state == ST_ACTIVE) | (bus.valid_in & rst_n);

endmodule
`default_nettype wire

// File: tb/tb_conv1_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1_window_buf
// Description : Self-checking bench for conv1_window_buf. A frame-image model
//               pushes expected windows to a queue as beats are driven; they
//               are popped and compared when valid_out appears.
// Config      : CONV1_BUF_SOF_EN enables the start-of-frame abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_window_buf;

  localparam int DB = 8;
  localparam int W  = 28;
  localparam int K  = 5;
  localparam int WB = K * K * DB;
`ifdef CONV1_BUF_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic gclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 gclk = ~gclk;

  conv1_window_buf_if #(.DATA_BITS(DB), .KERNEL(K)) bus ();

  conv1_window_buf #(.DATA_BITS(DB), .IMG_WIDTH(W), .KERNEL(K)) dut (
    .gclk  (gclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            mx, my;
  bit            mactive;
  bit            exp_vo, exp_fd;
  logic [WB-1:0] exp_q [$];
  logic [WB-1:0] last_win;
  logic [DB-1:0] img [W][W];
  int            vo_cnt, fd_cnt, sel_idx;
  logic [WB-1:0] first_win, final_win, sel_win;

  function automatic logic [DB-1:0] pix(input int pat, input int x, input int y);
    if (pat == 0) return DB'((y * W + x) % 256);
    return DB'((x * 7 + y * 13 + 101) % 256);
  endfunction

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    vo_cnt  = 0;
    fd_cnt  = 0;
    sel_idx = 0;
  endtask

  // Compare the registered outputs produced by the previous rising edge.
  task automatic check_outputs();
    logic [WB-1:0] e;
    check("valid_out", WB'(bus.valid_out), WB'(exp_vo));
    check("frame_done", WB'(bus.frame_done), WB'(exp_fd));
    if (bus.valid_out)  vo_cnt++;
    if (bus.frame_done) fd_cnt++;
    if (exp_vo) begin
      e = exp_q.pop_front();
      check("window", bus.window, e);
      last_win = e;
      if (vo_cnt == 1) first_win = bus.window;
      if (vo_cnt == sel_idx) sel_win = bus.window;
      final_win = bus.window;
    end else begin
      check("window_hold", bus.window, last_win);
    end
  endtask

  task automatic tick(input logic v, input logic [DB-1:0] d, input logic s);
    logic [WB-1:0] e;
    bit            exp_busy;
    @(negedge gclk);
    check_outputs();
    bus.valid_in = v;
    bus.data_in  = d;
`ifdef CONV1_BUF_SOF_EN
    bus.sof_in   = s;
`endif
    exp_busy = mactive | v;
    exp_vo   = 1'b0;
    exp_fd   = 1'b0;
    if (v) begin
      if (s && SOF_EN) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = d;
      if (mx >= K - 1 && my >= K - 1) begin
        e = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            e[(r*K+c)*DB +: DB] = img[my-K+1+r][mx-K+1+c];
        exp_q.push_back(e);
        exp_vo = 1'b1;
      end
      if (mx == W - 1 && my == W - 1) begin
        exp_fd  = 1'b1;
        mactive = 1'b0;
        mx      = 0;
        my      = 0;
      end else begin
        mactive = 1'b1;
        if (mx == W - 1) begin
          mx = 0;
          my++;
        end else begin
          mx++;
        end
      end
    end
    #1;
    check("busy", WB'(bus.busy), WB'(exp_busy));
  endtask

  task automatic check_zero();
    check("rst_valid_out", WB'(bus.valid_out), '0);
    check("rst_frame_done", WB'(bus.frame_done), '0);
    check("rst_busy", WB'(bus.busy), '0);
    check("rst_window", bus.window, '0);
  endtask

  task automatic do_reset(input int n);
    @(negedge gclk);
    check_outputs();
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
`ifdef CONV1_BUF_SOF_EN
    bus.sof_in   = 1'b0;
`endif
    mx = 0; my = 0; mactive = 1'b0;
    exp_vo = 1'b0; exp_fd = 1'b0;
    exp_q.delete();
    last_win = '0;
    #1;
    check_zero();
    repeat (n) begin
      @(negedge gclk);
      check_zero();
    end
    rst_n = 1'b1;
  endtask

  task automatic feed_frame(input int pat, input int maxgap, input int nbeats, input bit sof_first);
    for (int i = 0; i < nbeats; i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) tick(1'b0, '0, 1'b0);
      tick(1'b1, pix(pat, i % W, i / W), sof_first && (i == 0));
    end
  endtask

  task automatic flush(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
`ifdef CONV1_BUF_SOF_EN
    bus.sof_in   = 1'b0;
`endif
    mx = 0; my = 0; mactive = 1'b0;
    exp_vo = 1'b0; exp_fd = 1'b0;
    last_win = '0;
    clear_counts();

    do_reset(3);

    // Long idle after reset: nothing moves.
    flush(1000);
    check("idle_vo_cnt", WB'(vo_cnt), WB'(0));

    // Continuous frame, pattern (y*28+x) mod 256.
    clear_counts();
    feed_frame(0, 0, W * W, 1'b0);
    flush(3);
    check("f1_vo_cnt", WB'(vo_cnt), WB'(576));
    check("f1_fd_cnt", WB'(fd_cnt), WB'(1));
    check("f1_first_e00", WB'(first_win[0 +: DB]), WB'(0));
    check("f1_first_e44", WB'(first_win[24*DB +: DB]), WB'(116));
    check("f1_last_e00", WB'(final_win[0 +: DB]), WB'(155));
    check("f1_last_e44", WB'(final_win[24*DB +: DB]), WB'(15));

    // Same frame with random 0..3 cycle gaps.
    clear_counts();
    feed_frame(0, 3, W * W, 1'b0);
    flush(3);
    check("gap_vo_cnt", WB'(vo_cnt), WB'(576));
    check("gap_fd_cnt", WB'(fd_cnt), WB'(1));

    // Two back-to-back frames with different content.
    clear_counts();
    sel_idx = 577;
    feed_frame(0, 0, W * W, 1'b0);
    feed_frame(1, 0, W * W, 1'b0);
    flush(3);
    check("b2b_vo_cnt", WB'(vo_cnt), WB'(1152));
    check("b2b_fd_cnt", WB'(fd_cnt), WB'(2));
    check("b2b_f2_e00", WB'(sel_win[0 +: DB]), WB'(101));

    // Reset at beat 400, then a full frame.
    feed_frame(1, 0, 399, 1'b0);
    do_reset(2);
    clear_counts();
    feed_frame(0, 0, W * W, 1'b0);
    flush(3);
    check("rst_vo_cnt", WB'(vo_cnt), WB'(576));
    check("rst_fd_cnt", WB'(fd_cnt), WB'(1));

`ifdef CONV1_BUF_SOF_EN
    // Abort after 300 beats with sof_in: 160 windows from the partial frame
    // (rows 4..9 full, row 10 columns 4..19) plus a full 576.
    clear_counts();
    feed_frame(0, 0, 300, 1'b0);
    feed_frame(1, 0, W * W, 1'b1);
    flush(3);
    check("sof_vo_cnt", WB'(vo_cnt), WB'(160 + 576));
    check("sof_fd_cnt", WB'(fd_cnt), WB'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
